// File: rtl/axi4lite_regbank.sv
// ----------------------------------------------------------------------------
// axi4lite_regbank
// AXI4-Lite slave register bank used as the control/status endpoint of IP
// blocks. The AW and W channels are accepted independently into one-entry
// holding buffers. A write commits once both buffers are full and the write
// response slot is free. Writes use a byte-lane merge under wstrb. Read-only
// registers (RO_MASK) return reg_in. Out-of-range indices answer SLVERR.
// Every successful write raises a one-cycle wr_pulse.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   s_axi_aw*             write address channel
//   s_axi_w*              write data channel (with byte strobes)
//   s_axi_b*              write response channel (OKAY=00, SLVERR=10)
//   s_axi_ar*             read address channel
//   s_axi_r*              read data channel (OKAY=00, SLVERR=10)
//   reg_out               register contents, reg i at slice i
//   reg_in                status inputs for read-only regs, sampled at AR accept
//   wr_pulse              one-cycle pulse per successful write to reg i
// ----------------------------------------------------------------------------
module axi4lite_regbank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 12,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int              STRB_W     = DATA_WIDTH / 8;
  localparam int              LSB        = $clog2(STRB_W);
  localparam int              IDX_W      = ADDR_WIDTH - LSB;
  localparam logic [IDX_W:0]  NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0]      RESP_OKAY  = 2'b00;
  localparam logic [1:0]      RESP_SLV   = 2'b10;

  // Holding buffers. Only the register index of the address is kept.
  logic                  r_aw_full;
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_w_full;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]     r_w_strb;

  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_commit;
  logic                  w_aw_in_range;
  logic                  w_aw_ro;
  logic                  w_wr_ok;
  logic [NUM_REGS-1:0]   w_we;
  logic                  w_arready;
  logic                  w_ar_hs;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_ar_in_range;
  logic [DATA_WIDTH-1:0] w_ar_data;
  logic                  w_unused;

  assign w_aw_hs  = s_axi_awvalid & ~r_aw_full;
  assign w_w_hs   = s_axi_wvalid & ~r_w_full;
  assign w_commit = r_aw_full & r_w_full & (~r_bvalid | s_axi_bready);

  assign w_aw_in_range = ({1'b0, r_aw_idx} < NUM_REGS_W);
  assign w_wr_ok       = w_aw_in_range & ~w_aw_ro;

  assign w_arready     = ~r_rvalid | s_axi_rready;
  assign w_ar_hs       = s_axi_arvalid & w_arready;
  assign w_ar_idx      = s_axi_araddr[ADDR_WIDTH-1:LSB];
  assign w_ar_in_range = ({1'b0, w_ar_idx} < NUM_REGS_W);

  // Address byte-offset bits and reg_in slices of read/write regs are
  // intentionally ignored.
  assign w_unused = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0], reg_in};

  // Index decode. An out-of-range index matches no register, so it yields
  // no write enable, RO=0 and read data 0.
  always_comb begin
    w_aw_ro   = 1'b0;
    w_ar_data = '0;
    w_we      = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_aw_idx == IDX_W'(i)) begin
        w_aw_ro = RO_MASK[i];
      end
      if (w_ar_idx == IDX_W'(i)) begin
        w_ar_data = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
      w_we[i] = w_commit & w_wr_ok & (r_aw_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:LSB];
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= s_axi_wdata;
        r_w_strb <= s_axi_wstrb;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
    end
  end

  // Register array with byte-lane merge. wstrb=0 still counts as a write
  // (pulse + OKAY) but leaves the data untouched.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_we;
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_we[i] && r_w_strb[b]) begin
            r_regs[i][8*b +: 8] <= r_w_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Write response: a commit always refills the slot, otherwise bready drains it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLV;
    end else if (s_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read pipeline, single stage. Data is captured at accept, so a read
  // alongside a commit to the same reg sees the pre-write value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLV;
      r_rdata  <= w_ar_in_range ? w_ar_data : '0;
    end else if (s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  assign s_axi_awready = ~r_aw_full;
  assign s_axi_wready  = ~r_w_full;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = w_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign wr_pulse      = r_wr_pulse;

endmodule
